// File: rtl/vec_player_pkg.sv
// Shared types for the vector player: packed stimulus vector layout and FSM states.
package vec_player_pkg;

  localparam int VAL_W = 3;
  localparam int VEC_W = 12;

  typedef struct packed {
    logic [VAL_W-1:0] exp;
    logic [VAL_W-1:0] in1;
    logic [VAL_W-1:0] in2;
    logic             a;
    logic             b;
    logic             c;
  } vec_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_WAIT,
    ST_CAPTURE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/vec_player_mem.sv
// Vector and response storage: synchronous writes, combinational reads, no reset.
module vec_player_mem
  import vec_player_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     vec_we,
  input  logic [$clog2(DEPTH)-1:0] vec_waddr,
  input  vec_t                     vec_wdata,
  input  logic [$clog2(DEPTH)-1:0] vec_raddr,
  output vec_t                     vec_rdata,
  input  logic                     resp_we,
  input  logic [$clog2(DEPTH)-1:0] resp_waddr,
  input  logic [VAL_W-1:0]         resp_wdata,
  input  logic [$clog2(DEPTH)-1:0] resp_raddr,
  output logic [VAL_W-1:0]         resp_rdata
);

  vec_t             vec_mem  [DEPTH];
  logic [VAL_W-1:0] resp_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (vec_we) vec_mem[vec_waddr] <= vec_wdata;
    if (resp_we) resp_mem[resp_waddr] <= resp_wdata;
  end

  assign vec_rdata  = vec_mem[vec_raddr];
  assign resp_rdata = resp_mem[resp_raddr];

endmodule

// File: rtl/vec_player.sv
// Replays stored vectors onto an exercise DUT, captures out1 after a settle delay
// and counts responses that differ from the stored expectation.
module vec_player
  import vec_player_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int SETTLE = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [VEC_W-1:0]           wr_data,
  input  logic                       start,
  input  logic [$clog2(DEPTH+1)-1:0] count,
  output logic [VAL_W-1:0]           in1,
  output logic [VAL_W-1:0]           in2,
  output logic                       a,
  output logic                       b,
  output logic                       c,
  input  logic [VAL_W-1:0]           dut_out,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [$clog2(DEPTH+1)-1:0] err_cnt,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [VAL_W-1:0]           rd_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int SW = $clog2(SETTLE+1);

  state_t           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    err_q, err_d, err_next;
  logic [SW-1:0]    settle_q, settle_d;
  logic [VAL_W-1:0] in1_q, in1_d, in2_q, in2_d;
  logic [2:0]       abc_q, abc_d;
  logic             pass_q, pass_d, busy_q, busy_d, done_q, done_d;

  vec_t cur_vec;
  logic vec_we, resp_we, last_vec;

  assign vec_we   = wr_en && (state_q == ST_IDLE);
  assign resp_we  = (state_q == ST_CAPTURE);
  assign last_vec = (CW'(idx_q) == (cnt_q - CW'(1)));

  vec_player_mem #(.DEPTH(DEPTH)) u_mem (
    .clk        (clk),
    .vec_we     (vec_we),
    .vec_waddr  (wr_addr),
    .vec_wdata  (vec_t'(wr_data)),
    .vec_raddr  (idx_q),
    .vec_rdata  (cur_vec),
    .resp_we    (resp_we),
    .resp_waddr (idx_q),
    .resp_wdata (dut_out),
    .resp_raddr (rd_addr),
    .resp_rdata (rd_data)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    err_next = err_q;
    settle_d = settle_q;
    in1_d    = in1_q;
    in2_d    = in2_q;
    abc_d    = abc_q;
    pass_d   = pass_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d   = (count > CW'(DEPTH)) ? CW'(DEPTH) : count;
          idx_d   = '0;
          err_d   = '0;
          pass_d  = 1'b0;
          state_d = ST_DRIVE;
        end
      end
      // An empty run still spends one busy cycle here before DONE.
      ST_DRIVE: begin
        if (cnt_q == '0) begin
          pass_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          in1_d    = cur_vec.in1;
          in2_d    = cur_vec.in2;
          abc_d    = {cur_vec.a, cur_vec.b, cur_vec.c};
          settle_d = '0;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (settle_q == SW'(SETTLE-1)) state_d = ST_CAPTURE;
        else settle_d = settle_q + 1'b1;
      end
      ST_CAPTURE: begin
        if ((dut_out != cur_vec.exp) && (err_q != CW'(DEPTH))) err_next = err_q + 1'b1;
        err_d = err_next;
        if (last_vec) begin
          pass_d  = (err_next == '0);
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_DRIVE;
        end
      end
      ST_DONE: begin
        in1_d   = '0;
        in2_d   = '0;
        abc_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      err_q    <= '0;
      settle_q <= '0;
      in1_q    <= '0;
      in2_q    <= '0;
      abc_q    <= '0;
      pass_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      settle_q <= settle_d;
      in1_q    <= in1_d;
      in2_q    <= in2_d;
      abc_q    <= abc_d;
      pass_q   <= pass_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign in1       = in1_q;
  assign in2       = in2_q;
  assign {a, b, c} = abc_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_vec_player.sv
// Directed bench for vec_player with a stub DUT out1 = a ? in1 : in2, run at SETTLE=1 and SETTLE=3.
module tb_vec_player;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [11:0] wr_data = '0;
  logic        start = 1'b0;
  logic        start3 = 1'b0;
  logic [3:0]  count = '0;
  logic [2:0]  rd_addr = '0;

  logic [2:0] in1, in2, dut_out, rd_data;
  logic       a, b, c, busy, done, pass;
  logic [3:0] err_cnt;

  logic [2:0] in1_3, in2_3, dut_out3, rd_data3;
  logic       a3, b3, c3, busy3, done3, pass3;
  logic [3:0] err_cnt3;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  assign dut_out  = a ? in1 : in2;
  assign dut_out3 = a3 ? in1_3 : in2_3;

  vec_player #(.DEPTH(8), .SETTLE(1)) u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .count(count), .in1(in1), .in2(in2), .a(a), .b(b), .c(c),
    .dut_out(dut_out), .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  vec_player #(.DEPTH(8), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start3), .count(count), .in1(in1_3), .in2(in2_3), .a(a3), .b(b3), .c(c3),
    .dut_out(dut_out3), .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err_cnt3),
    .rd_addr(rd_addr), .rd_data(rd_data3)
  );

  // Vector layout {exp, in1, in2, abc}; expected out1 derived by hand from a ? in1 : in2.
  logic [11:0] base_vec [4] = '{12'b010_101_010_000, 12'b101_101_010_100,
                                12'b010_101_010_011, 12'b010_101_010_010};
  logic [2:0]  base_resp [4] = '{3'b010, 3'b101, 3'b010, 3'b010};

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    else passed++;
  endtask

  task automatic loadVector(input logic [2:0] addr, input logic [11:0] data);
    wr_en = 1'b1; wr_addr = addr; wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic checkResp(input string tag, input logic [2:0] addr, input logic [2:0] exp);
    rd_addr = addr;
    #1;
    checkOutput(tag, rd_data, exp);
  endtask

  // Pulse start (optionally with a coincident write, or a start+write pulse mid-run)
  // and return the cycle on which done is seen, or -1 on timeout.
  task automatic applyStimulus(input logic [3:0] n, input bit co_wr, input bit disturb,
                               input logic [2:0] waddr, input logic [11:0] wdat, output int lat);
    count = n; start = 1'b1;
    if (co_wr) begin wr_en = 1'b1; wr_addr = waddr; wr_data = wdat; end
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0; lat = 1;
    checkOutput("busy_t1", busy, 1);
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
      if (disturb && lat == 3) begin
        start = 1'b1; wr_en = 1'b1; wr_addr = waddr; wr_data = wdat;
      end else begin
        start = 1'b0; wr_en = 1'b0;
      end
    end
    if (!done) lat = -1;
  endtask

  task automatic checkRun(input string pfx, input int lat, input int exp_lat,
                          input bit exp_pass, input int exp_err);
    checkOutput({pfx, "_lat"}, lat, exp_lat);
    checkOutput({pfx, "_pass"}, pass, exp_pass);
    checkOutput({pfx, "_err"}, err_cnt, exp_err);
    @(negedge clk);
    checkOutput({pfx, "_idle"}, {busy, done, in1, in2, a, b, c}, 0);
  endtask

  initial begin
    int lat;
    int hold;
    bit seen;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_drive", {in1, in2, a, b, c}, 0);
    checkOutput("rst_status", {busy, done, pass}, 0);
    checkOutput("rst_err", err_cnt, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) loadVector(3'(i), base_vec[i]);

    // Nominal run: 4 vectors at 3 cycles each plus one
    applyStimulus(4'd4, 1'b0, 1'b0, 3'd0, 12'd0, lat);
    checkRun("nominal", lat, 13, 1'b1, 0);
    for (int i = 0; i < 4; i++) checkResp($sformatf("nominal_rd%0d", i), 3'(i), base_resp[i]);

    // SETTLE=3: 4 vectors at 5 cycles each plus one
    count = 4'd4; start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0; lat = 1; hold = 0;
    while (!done3 && lat < 200) begin
      if ({a3, b3, c3} == 3'b100) hold++;
      @(negedge clk);
      lat++;
    end
    if (!done3) lat = -1;
    checkOutput("settle3_lat", lat, 21);
    checkOutput("settle3_pass", {pass3, err_cnt3}, 5'h10);
    checkOutput("settle3_stable4", hold >= 4, 1);
    rd_addr = 3'd1; #1;
    checkOutput("settle3_rd1", rd_data3, 3'b101);
    @(negedge clk);

    // Mismatch: slot 1 exp=111 written in the same cycle as start
    applyStimulus(4'd4, 1'b1, 1'b0, 3'd1, 12'b111_101_010_100, lat);
    checkRun("mismatch", lat, 13, 1'b0, 1);
    checkResp("mismatch_rd1", 3'd1, 3'b101);
    loadVector(3'd1, base_vec[1]);

    // Count 0: done two cycles after start, pass restored to 1
    applyStimulus(4'd0, 1'b0, 1'b0, 3'd0, 12'd0, lat);
    checkRun("count0", lat, 2, 1'b1, 0);

    // Clamp: count 15 plays exactly 8 vectors
    for (int i = 4; i < 7; i++) loadVector(3'(i), 12'b011_011_110_100);
    loadVector(3'd7, 12'b110_011_110_000);
    applyStimulus(4'd15, 1'b0, 1'b0, 3'd0, 12'd0, lat);
    checkRun("clamp", lat, 25, 1'b1, 0);
    checkResp("clamp_rd7", 3'd7, 3'b110);
    checkResp("clamp_rd4", 3'd4, 3'b011);

    // Start and wr_en pulsed mid-run are ignored
    applyStimulus(4'd4, 1'b0, 1'b1, 3'd3, 12'b111_000_000_100, lat);
    checkRun("busy_ign", lat, 13, 1'b1, 0);
    checkResp("busy_ign_rd3", 3'd3, 3'b010);
    checkResp("beyond_count_rd7", 3'd7, 3'b110);

    // Reset during WAIT of vector 2
    count = 4'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    checkOutput("prerst_abc", {busy, a, b, c}, 4'b1011);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_drive", {busy, in1, in2, a, b, c}, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checkOutput("midrst_nodone", seen, 0);
    applyStimulus(4'd4, 1'b0, 1'b0, 3'd0, 12'd0, lat);
    checkRun("after_rst", lat, 13, 1'b1, 0);
    checkResp("after_rst_rd2", 3'd2, 3'b010);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
